// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard detector: tracks in-flight destination registers for STAGES
// post-ID slots and produces a stall flag plus per-operand forwarding selects.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int STAGES     = 2,
  parameter int FORWARD_EN = 0,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] rn,
  input  logic [REG_ADDR_W-1:0] src_2,
  input  logic                  two_src,
  input  logic                  flush,
  input  logic                  freeze,
  output logic                  hazard_detected_signal,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic [CNT_W-1:0]      stall_count
);

  logic [STAGES-1:0]     r_valid;
  logic [STAGES-1:0]     r_wb_en;
  logic [STAGES-1:0]     r_load;
  logic [REG_ADDR_W-1:0] r_dest [STAGES];
  logic [CNT_W-1:0]      r_cnt;

  logic [STAGES-1:0] w_match_a;
  logic [STAGES-1:0] w_match_b;
  logic [SEL_W-1:0]  w_sel_a;
  logic [SEL_W-1:0]  w_sel_b;
  logic              w_any_match;
  logic              w_load_use;
  logic              w_hazard;
  logic              w_fwd_on;
  logic              w_admit;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_match
      assign w_match_a[gi] = id_valid & r_valid[gi] & r_wb_en[gi]
                             & (r_dest[gi] == rn);
      assign w_match_b[gi] = id_valid & two_src & r_valid[gi] & r_wb_en[gi]
                             & (r_dest[gi] == src_2);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching index is the one that sticks.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (w_match_a[i]) w_sel_a = SEL_W'(i + 1);
      if (w_match_b[i]) w_sel_b = SEL_W'(i + 1);
    end
  end

  assign w_any_match = (|w_match_a) | (|w_match_b);
  // Slot 0 is always the youngest, so a slot-0 match is the winning match.
  assign w_load_use  = r_load[0] & (w_match_a[0] | w_match_b[0]);
  assign w_hazard    = (FORWARD_EN != 0) ? w_load_use : w_any_match;
  assign w_fwd_on    = (FORWARD_EN != 0) & ~w_hazard;
  assign w_admit     = id_valid & ~w_hazard & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_wb_en <= '0;
      r_load  <= '0;
      r_cnt   <= '0;
    end else if (!freeze) begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        r_valid[i] <= r_valid[i-1];
        r_wb_en[i] <= r_wb_en[i-1];
        r_load[i]  <= r_load[i-1];
        r_dest[i]  <= r_dest[i-1];
      end
      r_valid[0] <= w_admit;
      r_wb_en[0] <= id_wb_en;
      r_load[0]  <= id_mem_read;
      r_dest[0]  <= id_dest;
      if (w_hazard && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign hazard_detected_signal = w_hazard;
  assign fwd_sel_a              = w_fwd_on ? w_sel_a : '0;
  assign fwd_sel_b              = w_fwd_on ? w_sel_b : '0;
  assign stall_count            = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: a stall-only instance (CNT_W=4)
// and a forwarding instance (STAGES=3), expectations queued per transaction.
module tb_hazard_scoreboard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       v0, wb0, ld0, two0, fl0, fz0, rs0;
  logic [3:0] dst0, rn0, s20;
  logic       hz0;
  logic [1:0] fa0, fb0;
  logic [3:0] cnt0;

  logic       v1, wb1, ld1, two1, fl1, fz1, rs1;
  logic [3:0] dst1, rn1, s21;
  logic       hz1;
  logic [1:0] fa1, fb1;
  logic [15:0] cnt1;

  hazard_scoreboard_unit #(
    .REG_ADDR_W(4), .STAGES(2), .FORWARD_EN(0), .CNT_W(4)
  ) dut0 (
    .clk(clk), .rst(rs0), .id_valid(v0), .id_wb_en(wb0), .id_dest(dst0),
    .id_mem_read(ld0), .rn(rn0), .src_2(s20), .two_src(two0), .flush(fl0),
    .freeze(fz0), .hazard_detected_signal(hz0), .fwd_sel_a(fa0),
    .fwd_sel_b(fb0), .stall_count(cnt0)
  );

  hazard_scoreboard_unit #(
    .REG_ADDR_W(4), .STAGES(3), .FORWARD_EN(1), .CNT_W(16)
  ) dut1 (
    .clk(clk), .rst(rs1), .id_valid(v1), .id_wb_en(wb1), .id_dest(dst1),
    .id_mem_read(ld1), .rn(rn1), .src_2(s21), .two_src(two1), .flush(fl1),
    .freeze(fz1), .hazard_detected_signal(hz1), .fwd_sel_a(fa1),
    .fwd_sel_b(fb1), .stall_count(cnt1)
  );

  typedef struct {
    string tag;
    int    d;
    int    hz;
    int    a;
    int    b;
    int    cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle on DUT d (the other is frozen and idle), queue the
  // expectation, check it mid-cycle, then advance past the clock edge.
  task automatic step(input int d, input bit v, input bit wb, input int dst,
                      input bit ld, input int rn, input int s2, input bit two,
                      input bit fl, input bit fz, input bit rs,
                      input int ehz, input int ea, input int eb, input int ecnt,
                      input string tag);
    exp_t e;
    if (d == 0) begin
      v0 = v; wb0 = wb; dst0 = dst[3:0]; ld0 = ld; rn0 = rn[3:0];
      s20 = s2[3:0]; two0 = two; fl0 = fl; fz0 = fz; rs0 = rs;
      v1 = 1'b0; fl1 = 1'b0; fz1 = 1'b1; rs1 = 1'b0;
    end else begin
      v1 = v; wb1 = wb; dst1 = dst[3:0]; ld1 = ld; rn1 = rn[3:0];
      s21 = s2[3:0]; two1 = two; fl1 = fl; fz1 = fz; rs1 = rs;
      v0 = 1'b0; fl0 = 1'b0; fz0 = 1'b1; rs0 = 1'b0;
    end
    e.tag = tag; e.d = d; e.hz = ehz; e.a = ea; e.b = eb; e.cnt = ecnt;
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    if (e.d == 0) begin
      chk({e.tag, "/hz"},  32'(hz0),  e.hz);
      chk({e.tag, "/fa"},  32'(fa0),  e.a);
      chk({e.tag, "/fb"},  32'(fb0),  e.b);
      chk({e.tag, "/cnt"}, 32'(cnt0), e.cnt);
      $display("txn %s dut0 hz=%0d fa=%0d fb=%0d cnt=%0d", e.tag, hz0, fa0, fb0, cnt0);
    end else begin
      chk({e.tag, "/hz"},  32'(hz1),  e.hz);
      chk({e.tag, "/fa"},  32'(fa1),  e.a);
      chk({e.tag, "/fb"},  32'(fb1),  e.b);
      chk({e.tag, "/cnt"}, 32'(cnt1), e.cnt);
      $display("txn %s dut1 hz=%0d fa=%0d fb=%0d cnt=%0d", e.tag, hz1, fa1, fb1, cnt1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ecnt;
    int ehz;
    v0 = 0; wb0 = 0; dst0 = 0; ld0 = 0; rn0 = 0; s20 = 0; two0 = 0; fl0 = 0; fz0 = 0; rs0 = 1;
    v1 = 0; wb1 = 0; dst1 = 0; ld1 = 0; rn1 = 0; s21 = 0; two1 = 0; fl1 = 0; fz1 = 0; rs1 = 1;
    repeat (2) @(posedge clk);
    #1;
    rs0 = 0;
    rs1 = 0;

    // Stall-only instance
    //   d  v  wb dst ld rn s2 two fl fz rs   hz a  b  cnt
    step(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  "rst0");
    step(0, 1, 1, 3,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  "t1_wr3");
    step(0, 1, 1, 1,  0, 3, 0, 0,  0, 0, 0,   1, 0, 0, 0,  "t1_st1");
    step(0, 1, 1, 1,  0, 3, 0, 0,  0, 0, 0,   1, 0, 0, 1,  "t1_st2");
    step(0, 1, 1, 1,  0, 3, 0, 0,  0, 0, 0,   0, 0, 0, 2,  "t1_go");
    step(0, 1, 1, 5,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2,  "t2_wr5");
    step(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2,  "t2_nop");
    step(0, 1, 0, 0,  0, 8, 5, 0,  0, 1, 0,   0, 0, 0, 2,  "t2_one");
    step(0, 1, 0, 0,  0, 8, 5, 1,  0, 0, 0,   1, 0, 0, 2,  "t2_two");
    step(0, 1, 0, 0,  0, 8, 5, 1,  0, 0, 0,   0, 0, 0, 3,  "t2_go");
    step(0, 1, 1, 6,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 3,  "t4_wr6");
    for (int k = 0; k < 3; k++)
      step(0, 1, 0, 0, 0, 6, 0, 0, 0, 1, 0,   1, 0, 0, 3,  "t4_frz");
    step(0, 1, 0, 0,  0, 6, 0, 0,  0, 0, 0,   1, 0, 0, 3,  "t4_st1");
    step(0, 1, 0, 0,  0, 6, 0, 0,  0, 0, 0,   1, 0, 0, 4,  "t4_st2");
    step(0, 1, 0, 0,  0, 6, 0, 0,  0, 0, 0,   0, 0, 0, 5,  "t4_go");
    step(0, 1, 1, 2,  0, 0, 0, 0,  1, 0, 0,   0, 0, 0, 5,  "t5_fl");
    step(0, 1, 0, 0,  0, 2, 0, 0,  0, 0, 0,   0, 0, 0, 5,  "t5_rd2");
    step(0, 1, 1, 9,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 5,  "t5_wr9");
    step(0, 1, 0, 0,  0, 9, 0, 0,  0, 1, 1,   1, 0, 0, 5,  "t5_rst");
    step(0, 1, 0, 0,  0, 9, 0, 0,  0, 0, 0,   0, 0, 0, 0,  "t5_clr");
    step(0, 1, 1, 10, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  "t6_wr10");
    // R10 <- R10 presented continuously: stalls twice, admits once, repeats.
    ecnt = 0;
    for (int k = 0; k < 24; k++) begin
      ehz = ((k % 3) != 2) ? 1 : 0;
      step(0, 1, 1, 10, 0, 10, 0, 0, 0, 0, 0, ehz, 0, 0, ecnt, "t6_loop");
      if (ehz == 1 && ecnt < 15) ecnt++;
    end
    step(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 15, "t6_sat");

    // Forwarding instance
    step(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  "rst1");
    step(1, 1, 1, 4,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  "t3_wr4");
    step(1, 1, 1, 1,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  "t3_wr1");
    step(1, 1, 1, 4,  0, 1, 4, 1,  0, 0, 0,   0, 1, 2, 0,  "t3_fwd");
    step(1, 1, 0, 0,  0, 4, 1, 1,  0, 0, 0,   0, 1, 2, 0,  "t3_young");
    step(1, 1, 1, 7,  1, 4, 0, 0,  0, 0, 0,   0, 2, 0, 0,  "t3_ld7");
    step(1, 1, 0, 0,  0, 4, 7, 1,  0, 0, 0,   1, 0, 0, 0,  "t3_ldu");
    step(1, 1, 0, 0,  0, 4, 7, 1,  0, 0, 0,   0, 0, 2, 1,  "t3_fwdb");
    step(1, 1, 0, 0,  0, 7, 0, 0,  0, 0, 0,   0, 3, 0, 1,  "t3_old");
    step(1, 1, 1, 12, 0, 12, 0, 0, 0, 0, 0,   0, 0, 0, 1,  "t3_self");
    step(1, 1, 1, 8,  1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1,  "t3_ld8");
    step(1, 1, 0, 0,  0, 8, 8, 1,  0, 1, 0,   1, 0, 0, 1,  "t3_frz");
    step(1, 1, 0, 0,  0, 8, 8, 1,  0, 0, 0,   1, 0, 0, 1,  "t3_ldu2");
    step(1, 1, 0, 0,  0, 8, 8, 1,  0, 0, 0,   0, 2, 2, 2,  "t3_fwd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised hazard detection and forwarding-select unit at the ID stage of the ARM pipeline.
- Keeps an internal shift scoreboard of in-flight destination registers for STAGES stages after ID (slot 0 = EXE, slot 1 = MEM, …).
- Raises a stall when an ID source depends on an unfinished write.
- When forwarding is enabled, returns the youngest producing stage per operand and stalls only on load-use.

Parameters:
- REG_ADDR_W, 4, register index width.
- STAGES, 2, number of tracked post-ID stages, 1..6.
- FORWARD_EN, 0, 0 = stall on any RAW match; 1 = forward, stall only on load-use from slot 0.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_wb_en  in  1  ID instruction writes a register.
- id_dest  in  REG_ADDR_W  ID destination register.
- id_mem_read  in  1  ID instruction is a load.
- rn  in  REG_ADDR_W  first source register.
- src_2  in  REG_ADDR_W  second source register.
- two_src  in  1  src_2 is a real operand.
- flush  in  1  branch taken; the ID instruction is killed.
- freeze  in  1  memory stall; the whole pipeline holds.
- hazard_detected_signal  out  1  stall IF/ID, inject a bubble into EXE.
- fwd_sel_a  out  clog2(STAGES+1)  rn source: 0 = register file, k = slot k-1.
- fwd_sel_b  out  clog2(STAGES+1)  src_2 source, same encoding.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Slot contents: each slot holds {valid, wb_en, dest, is_load}.
- Reset: all slots invalid and stall_count = 0. Hence hazard_detected_signal = 0 and fwd_sel_a/b = 0 in the first cycle after reset.
- Match rule for slot i and source s: valid[i] & wb_en[i] & dest[i] == s.
  - rn is always checked when id_valid = 1.
  - src_2 is checked only when id_valid & two_src.
  - id_valid = 0 gives no matches.
- Priority: the youngest matching slot (lowest index) wins.
- FORWARD_EN = 0:
  - hazard_detected_signal = any match on either operand.
  - fwd_sel_a and fwd_sel_b are constant 0.
- FORWARD_EN = 1:
  - hazard_detected_signal = 1 when the youngest match for either operand is slot 0 with is_load = 1.
  - Otherwise fwd_sel = youngest matching index + 1, or 0 if there is no match.
  - While a hazard is asserted, both fwd_sel outputs read 0.
- hazard_detected_signal and fwd_sel are combinational from the current slots and the ID inputs. They are valid in the same cycle and are still computed during freeze.
- Shift at the clock edge, when rst = 0 and freeze = 0:
  - slot[i] <= slot[i-1] for i ≥ 1.
  - slot[0] <= ID entry if id_valid & !hazard_detected_signal & !flush; otherwise a bubble (valid = 0).
- freeze = 1: all slots and stall_count hold. freeze has priority over flush, so a flush during freeze has no effect.
- flush only bubbles slot 0. Older slots still advance normally.
- stall_count increments when hazard_detected_signal & !freeze & !rst, and saturates at all ones.
- Stall resolution:
  - FORWARD_EN = 0: a dependent instruction stalls until the producer leaves slot STAGES-1.
  - FORWARD_EN = 1: a load-use stall lasts exactly one unfrozen cycle.
- Self-dependence (id_dest == rn) creates no hazard against the ID instruction itself.
- Reset mid-operation clears all in-flight state the next edge and has priority over freeze.

Test Plan:
1. FORWARD_EN=0, STAGES=2: ALU writes R3, next instruction reads rn=R3 -> hazard=1 for 2 cycles, then 0; stall_count = 2.
2. FORWARD_EN=0: src_2=R5 matches slot 1, two_src=0 -> hazard=0. Same with two_src=1 -> hazard=1.
3. FORWARD_EN=1, STAGES=3: R4 written in slots 0 and 2, rn=R4 -> fwd_sel_a=1, hazard=0. Load to R7 in slot 0, src_2=R7, two_src=1 -> hazard=1 for one cycle, then fwd_sel_b=2.
4. Hazard pending, freeze=1 for 3 cycles -> hazard stays 1, slots and stall_count unchanged. freeze falls -> normal resolution.
5. flush=1 with a valid ID writer of R2, next instruction reads R2 -> hazard=0 (bubble inserted). rst mid-stall -> hazard=0, stall_count=0 next cycle.
6. Saturation: CNT_W=4, hold a continuous hazard for 20 cycles -> stall_count = 15.
